// File: rtl/arc4_pkg.sv
// rtl/arc4_pkg.sv - shared state, phase encodings and watchdog width for arc4_seq.
// ARC4_SEQ_TIMEOUT_EN adds the ERR state.
package arc4_pkg;

`ifdef ARC4_SEQ_TIMEOUT_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT_GO, ST_INIT_WAIT, ST_KSA_GO, ST_KSA_WAIT,
    ST_PRGA_GO, ST_PRGA_WAIT, ST_ERR
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT_GO, ST_INIT_WAIT, ST_KSA_GO, ST_KSA_WAIT,
    ST_PRGA_GO, ST_PRGA_WAIT
  } state_e;
`endif

  typedef enum logic [1:0] {
    PH_NONE = 2'd0,
    PH_INIT = 2'd1,
    PH_KSA  = 2'd2,
    PH_PRGA = 2'd3
  } phase_e;

  localparam int WDOG_W = 16;

  // Ownership follows the state directly, so it changes on the same edge as *_GO entry.
  function automatic phase_e phase_of(state_e s);
    case (s)
      ST_INIT_GO, ST_INIT_WAIT: return PH_INIT;
      ST_KSA_GO,  ST_KSA_WAIT:  return PH_KSA;
      ST_PRGA_GO, ST_PRGA_WAIT: return PH_PRGA;
      default:                  return PH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/arc4_mem_mux.sv
// rtl/arc4_mem_mux.sv - single-port S-memory grant mux, selected by current phase.
// Non-owner requests are dropped; no owner drives an all-zero idle port.
module arc4_mem_mux
  import arc4_pkg::*;
(
  input  logic [1:0] phase_i,
  input  logic [7:0] init_addr_i,
  input  logic [7:0] init_wrdata_i,
  input  logic       init_wren_i,
  input  logic [7:0] ksa_addr_i,
  input  logic [7:0] ksa_wrdata_i,
  input  logic       ksa_wren_i,
  input  logic [7:0] prga_addr_i,
  input  logic [7:0] prga_wrdata_i,
  input  logic       prga_wren_i,
  output logic [7:0] s_addr_o,
  output logic [7:0] s_wrdata_o,
  output logic       s_wren_o
);

  always_comb begin
    s_addr_o   = 8'd0;
    s_wrdata_o = 8'd0;
    s_wren_o   = 1'b0;
    case (phase_i)
      PH_INIT: begin
        s_addr_o   = init_addr_i;
        s_wrdata_o = init_wrdata_i;
        s_wren_o   = init_wren_i;
      end
      PH_KSA: begin
        s_addr_o   = ksa_addr_i;
        s_wrdata_o = ksa_wrdata_i;
        s_wren_o   = ksa_wren_i;
      end
      PH_PRGA: begin
        s_addr_o   = prga_addr_i;
        s_wrdata_o = prga_wrdata_i;
        s_wren_o   = prga_wren_i;
      end
      default: begin
        s_addr_o   = 8'd0;
        s_wrdata_o = 8'd0;
        s_wren_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/arc4_seq.sv
// rtl/arc4_seq.sv - sequences init, ksa and prga engines and arbitrates their S-memory port.
// ARC4_SEQ_TIMEOUT_EN adds a per-phase watchdog that traps into ERR until reset.
module arc4_seq
  import arc4_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [23:0] key_out,
  output logic        init_en,
  output logic        ksa_en,
  output logic        prga_en,
  input  logic        init_rdy,
  input  logic        ksa_rdy,
  input  logic        prga_rdy,
  input  logic [7:0]  init_addr,
  input  logic [7:0]  init_wrdata,
  input  logic        init_wren,
  input  logic [7:0]  ksa_addr,
  input  logic [7:0]  ksa_wrdata,
  input  logic        ksa_wren,
  input  logic [7:0]  prga_addr,
  input  logic [7:0]  prga_wrdata,
  input  logic        prga_wren,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_wrdata,
  output logic        s_wren,
  input  logic [7:0]  s_rddata,
  output logic [7:0]  rddata,
  output logic [1:0]  phase
);

  state_e      state_q, state_d;
  logic [23:0] key_q, key_d;
  logic        started_q, started_d;
  logic        init_en_q, init_en_d;
  logic        ksa_en_q, ksa_en_d;
  logic        prga_en_q, prga_en_d;
`ifdef ARC4_SEQ_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      key_q     <= 24'd0;
      started_q <= 1'b0;
      init_en_q <= 1'b0;
      ksa_en_q  <= 1'b0;
      prga_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      started_q <= started_d;
      init_en_q <= init_en_d;
      ksa_en_q  <= ksa_en_d;
      prga_en_q <= prga_en_d;
    end
  end

`ifdef ARC4_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end
`endif

  // started_q marks that the engine has dropped rdy, so the next rdy=1 means done.
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    started_d = started_q;
    init_en_d = 1'b0;
    ksa_en_d  = 1'b0;
    prga_en_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          key_d   = key;
          state_d = ST_INIT_GO;
        end
      end
      ST_INIT_GO: begin
        started_d = 1'b0;
        if (init_rdy) begin
          init_en_d = 1'b1;
          state_d   = ST_INIT_WAIT;
        end
      end
      ST_INIT_WAIT: begin
        if (!init_rdy)      started_d = 1'b1;
        else if (started_q) state_d   = ST_KSA_GO;
      end
      ST_KSA_GO: begin
        started_d = 1'b0;
        if (ksa_rdy) begin
          ksa_en_d = 1'b1;
          state_d  = ST_KSA_WAIT;
        end
      end
      ST_KSA_WAIT: begin
        if (!ksa_rdy)       started_d = 1'b1;
        else if (started_q) state_d   = ST_PRGA_GO;
      end
      ST_PRGA_GO: begin
        started_d = 1'b0;
        if (prga_rdy) begin
          prga_en_d = 1'b1;
          state_d   = ST_PRGA_WAIT;
        end
      end
      ST_PRGA_WAIT: begin
        if (!prga_rdy)      started_d = 1'b1;
        else if (started_q) state_d   = ST_IDLE;
      end
      default: state_d = state_q;
    endcase

`ifdef ARC4_SEQ_TIMEOUT_EN
    wdog_d = wdog_q;
    case (state_q)
      ST_INIT_GO, ST_KSA_GO, ST_PRGA_GO: wdog_d = '0;
      ST_INIT_WAIT, ST_KSA_WAIT, ST_PRGA_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        if (wdog_q == {WDOG_W{1'b1}} && state_d == state_q) state_d = ST_ERR;
      end
      default: wdog_d = wdog_q;
    endcase
`endif
  end

  assign rdy     = (state_q == ST_IDLE);
  assign key_out = key_q;
  assign init_en = init_en_q;
  assign ksa_en  = ksa_en_q;
  assign prga_en = prga_en_q;
  assign phase   = phase_of(state_q);
  assign rddata  = s_rddata;

  arc4_mem_mux u_mux (
    .phase_i       (phase),
    .init_addr_i   (init_addr),
    .init_wrdata_i (init_wrdata),
    .init_wren_i   (init_wren),
    .ksa_addr_i    (ksa_addr),
    .ksa_wrdata_i  (ksa_wrdata),
    .ksa_wren_i    (ksa_wren),
    .prga_addr_i   (prga_addr),
    .prga_wrdata_i (prga_wrdata),
    .prga_wren_i   (prga_wren),
    .s_addr_o      (s_addr),
    .s_wrdata_o    (s_wrdata),
    .s_wren_o      (s_wren)
  );

endmodule

// File: tb/tb_arc4_seq.sv
// tb/tb_arc4_seq.sv - directed bench for arc4_seq with hand-sequenced engine handshakes.
// Define ARC4_SEQ_TIMEOUT_EN to also exercise the watchdog trap.
module tb_arc4_seq;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [23:0] key;
  logic        init_rdy, ksa_rdy, prga_rdy;
  logic [7:0]  init_addr, init_wrdata, ksa_addr, ksa_wrdata, prga_addr, prga_wrdata;
  logic        init_wren, ksa_wren, prga_wren;
  logic [7:0]  s_rddata;
  logic        rdy, init_en, ksa_en, prga_en, s_wren;
  logic [23:0] key_out;
  logic [7:0]  s_addr, s_wrdata, rddata;
  logic [1:0]  phase;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  arc4_seq dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key), .key_out(key_out),
    .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
    .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
    .init_addr(init_addr), .init_wrdata(init_wrdata), .init_wren(init_wren),
    .ksa_addr(ksa_addr), .ksa_wrdata(ksa_wrdata), .ksa_wren(ksa_wren),
    .prga_addr(prga_addr), .prga_wrdata(prga_wrdata), .prga_wren(prga_wren),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .s_rddata(s_rddata), .rddata(rddata), .phase(phase)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic eng_en(input int w);
    case (w)
      0:       return init_en;
      1:       return ksa_en;
      default: return prga_en;
    endcase
  endfunction

  task automatic set_rdy(input int w, input logic v);
    case (w)
      0:       init_rdy = v;
      1:       ksa_rdy  = v;
      default: prga_rdy = v;
    endcase
  endtask

  // Waits (bounded) for an engine start pulse, checks owner and single-cycle width.
  task automatic wait_pulse(input int w, input int budget, input string tag);
    int n = 0;
    while (!eng_en(w) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_seen"}, {31'd0, eng_en(w)}, 32'd1);
    check({tag, "_phase"}, {30'd0, phase}, w + 1);
    check({tag, "_excl"}, {29'd0, init_en, ksa_en, prga_en}, 32'd1 << (2 - w));
    step();
    check({tag, "_one_cycle"}, {31'd0, eng_en(w)}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; key = 24'd0;
    init_rdy = 1'b1; ksa_rdy = 1'b1; prga_rdy = 1'b1;
    init_addr = 8'd0; init_wrdata = 8'd0; init_wren = 1'b0;
    ksa_addr = 8'd0; ksa_wrdata = 8'd0; ksa_wren = 1'b0;
    prga_addr = 8'd0; prga_wrdata = 8'd0; prga_wren = 1'b0;
    s_rddata = 8'd0;
    step(); step();
    check("rst_rdy", {31'd0, rdy}, 32'd1);
    check("rst_phase", {30'd0, phase}, 32'd0);
    check("rst_ens", {29'd0, init_en, ksa_en, prga_en}, 32'd0);
    check("rst_swren", {31'd0, s_wren}, 32'd0);
    check("rst_key", {8'd0, key_out}, 32'd0);

    // Run 1: start in the first cycle after reset release.
    rst = 1'b0; en = 1'b1; key = 24'h000018;
    step();
    en = 1'b0;
    check("r1_rdy_busy", {31'd0, rdy}, 32'd0);
    check("r1_phase_init", {30'd0, phase}, 32'd1);
    check("r1_key_latched", {8'd0, key_out}, 32'h000018);
    check("r1_no_early_en", {31'd0, init_en}, 32'd0);
    wait_pulse(0, 1, "r1_init");

    init_rdy = 1'b0;
    init_addr = 8'h5A; init_wrdata = 8'h33; init_wren = 1'b1;
    ksa_addr = 8'h77; ksa_wrdata = 8'hEE; ksa_wren = 1'b1;
    s_rddata = 8'hC3;
    #1;
    check("grant_addr", {24'd0, s_addr}, 32'h5A);
    check("grant_wrdata", {24'd0, s_wrdata}, 32'h33);
    check("grant_wren", {31'd0, s_wren}, 32'd1);
    check("rddata_fanout", {24'd0, rddata}, 32'hC3);
    init_wren = 1'b0;
    #1;
    check("grant_ksa_ignored", {31'd0, s_wren}, 32'd0);
    ksa_wren = 1'b0;
    repeat (256) step();
    init_rdy = 1'b1;
    wait_pulse(1, 8, "r1_ksa");

    ksa_rdy = 1'b0;
    key = 24'hFFFFFF; en = 1'b1;
    repeat (4) step();
    check("ign_phase", {30'd0, phase}, 32'd2);
    check("ign_key", {8'd0, key_out}, 32'h000018);
    check("ign_rdy", {31'd0, rdy}, 32'd0);
    en = 1'b0; key = 24'd0;
    repeat (764) step();
    ksa_rdy = 1'b1;
    wait_pulse(2, 8, "r1_prga");

    prga_rdy = 1'b0;
    repeat (40) step();
    check("r1_key_hold", {8'd0, key_out}, 32'h000018);
    prga_rdy = 1'b1;
    step();
    check("r1_done_rdy", {31'd0, rdy}, 32'd1);
    check("r1_done_phase", {30'd0, phase}, 32'd0);

    // Run 2: back-to-back start, ksa engine busy at KSA_GO.
    en = 1'b1; key = 24'h0A0B0C;
    step();
    en = 1'b0;
    check("r2_phase_init", {30'd0, phase}, 32'd1);
    check("r2_key", {8'd0, key_out}, 32'h0A0B0C);
    wait_pulse(0, 2, "r2_init");
    init_rdy = 1'b0; ksa_rdy = 1'b0;
    repeat (10) step();
    init_rdy = 1'b1;
    step();
    check("r2_phase_ksa", {30'd0, phase}, 32'd2);
    for (int i = 0; i < 5; i++) begin
      check("r2_ksa_withheld", {31'd0, ksa_en}, 32'd0);
      step();
    end
    ksa_rdy = 1'b1;
    step();
    check("r2_ksa_pulse", {31'd0, ksa_en}, 32'd1);
    step();
    ksa_rdy = 1'b0;
    repeat (5) step();
    ksa_rdy = 1'b1;
    wait_pulse(2, 8, "r2_prga");

    prga_rdy = 1'b0; prga_wren = 1'b1; prga_addr = 8'h99;
    step();
    #1;
    check("r2_prga_wren", {31'd0, s_wren}, 32'd1);
    check("r2_prga_addr", {24'd0, s_addr}, 32'h99);
    rst = 1'b1;
    #1;
    check("midrst_phase", {30'd0, phase}, 32'd0);
    check("midrst_swren", {31'd0, s_wren}, 32'd0);
    check("midrst_rdy", {31'd0, rdy}, 32'd1);
    check("midrst_key", {8'd0, key_out}, 32'd0);
    prga_wren = 1'b0; prga_rdy = 1'b1;
    step();
    rst = 1'b0;

`ifdef ARC4_SEQ_TIMEOUT_EN
    en = 1'b1; key = 24'h123456;
    step();
    en = 1'b0;
    wait_pulse(0, 4, "to_init");
    init_rdy = 1'b0;
    repeat (65534) step();
    check("to_pre_phase", {30'd0, phase}, 32'd1);
    step();
    check("to_err_phase", {30'd0, phase}, 32'd0);
    check("to_err_rdy", {31'd0, rdy}, 32'd0);
    en = 1'b1;
    repeat (3) step();
    check("to_err_sticky", {31'd0, rdy}, 32'd0);
    en = 1'b0;
    rst = 1'b1;
    #1;
    check("to_rst_rdy", {31'd0, rdy}, 32'd1);
    step();
    rst = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
